// File: rtl/bus_pkg.sv
// Shared definitions for the burst bus and its memory-backed target.
//   - state_e   : target state encoding
//   - BURST_W / BE_W / DATA_W : bus field widths
//   - in_window : address decode helper for a power-of-two word window
package bus_pkg;

  localparam int BURST_W = 8;
  localparam int BE_W    = 4;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_READ,
    S_READ_END,
    S_ERROR
  } state_e;

  // A window of 2^aw 32-bit words spans 2^(aw+2) bytes, so only the bits
  // above that span take part in the decode.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          aw);
    return (addr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

endpackage

// File: rtl/bus_target_ram_if.sv
// Burst bus signal bundle.
//   master : initiator side (drives the *IN signals of the target)
//   slave  : target side (drives the *OUT signals)
interface bus_target_ram_if;
  import bus_pkg::*;

  logic [DATA_W-1:0]  address_dataIN;
  logic [BE_W-1:0]    byte_enableIN;
  logic [BURST_W-1:0] burst_sizeIN;
  logic               read_n_writeIN;
  logic               begin_transactionIN;
  logic               end_transactionIN;
  logic               data_validIN;
  logic               busyIN;

  logic [DATA_W-1:0]  address_dataOUT;
  logic               end_transactionOUT;
  logic               data_validOUT;
  logic               busyOUT;
  logic               bus_errorOUT;

  modport master (
    output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT,
           bus_errorOUT
  );

  modport slave (
    input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT,
           bus_errorOUT
  );

endinterface

// File: rtl/sp_ram_be.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with byte write enables and a registered
// read port. The read register only updates on a read, so it doubles as the
// holding register for a stalled read beat.
//   clock : clock
//   en    : access enable
//   we    : 1 = write, 0 = read (when en)
//   be    : byte lanes for writes
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (holds between reads)
module sp_ram_be
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];

  // NOTE: the array has no reset; contents are only defined once written,
  // which lets synthesis map it onto a RAM macro.
  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (en && !we) rdata <= mem_q[addr];
  end

endmodule

// File: rtl/bus_target_ram.sv
// Memory-backed burst bus target. Decodes begin cycles to its window, then
// accepts write bursts into RAM or streams read bursts out of it, with
// optional wait states, initiator back-pressure on reads and a one-cycle
// error pulse for out-of-range bursts or surplus write beats.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave side of the burst bus; all outputs are 0 when idle
module bus_target_ram
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h00F0_0000,
  parameter int          ADDR_WIDTH   = 9,
  parameter int          WAIT_STATES  = 0
) (
  input logic             clock,
  input logic             reset,
  bus_target_ram_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;    // next RAM word to touch
  logic [BURST_W-1:0]    cnt_q, cnt_d;      // write beats / read transfers left - 1
  logic [BURST_W-1:0]    iss_q, iss_d;      // read issues left - 1
  logic                  done_q, done_d;    // all writes accepted / all reads issued
  logic                  rnw_q, rnw_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [3:0]            wait_q, wait_d;
  logic                  rd_vld_q, rd_vld_d; // RAM read register holds a live beat

  logic                  ram_en, ram_we, xfer;
  logic [DATA_W-1:0]     ram_rdata;
  logic [ADDR_WIDTH-1:0] begin_word;
  logic [31:0]           span_end;
  logic                  dv_out;

  assign begin_word = bus.address_dataIN[ADDR_WIDTH+1:2];
  // One past the last word of the burst; must not exceed the window size.
  assign span_end   = 32'(begin_word) + 32'(bus.burst_sizeIN) + 32'd1;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    iss_d    = iss_q;
    done_d   = done_q;
    rnw_d    = rnw_q;
    be_d     = be_q;
    wait_d   = wait_q;
    rd_vld_d = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    xfer     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.begin_transactionIN &&
            in_window(bus.address_dataIN, BASE_ADDRESS, ADDR_WIDTH)) begin
          word_d = begin_word;
          cnt_d  = bus.burst_sizeIN;
          iss_d  = bus.burst_sizeIN;
          done_d = 1'b0;
          rnw_d  = bus.read_n_writeIN;
          be_d   = bus.byte_enableIN;
          wait_d = 4'(WAIT_STATES - 1);
          if (span_end > (32'd1 << ADDR_WIDTH)) state_d = S_ERROR;
          else if (WAIT_STATES > 0)             state_d = S_WAIT;
          else state_d = bus.read_n_writeIN ? S_READ : S_WRITE;
        end
      end

      S_WAIT: begin
        if (wait_q == 4'd0) state_d = rnw_q ? S_READ : S_WRITE;
        else                wait_d  = wait_q - 4'd1;
      end

      S_WRITE: begin
        if (bus.data_validIN && done_q) begin
          state_d = S_ERROR;  // surplus beat: drop it and flag
        end else begin
          if (bus.data_validIN) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            word_d = word_q + ADDR_WIDTH'(1);
            if (cnt_q == '0) done_d = 1'b1;
            else             cnt_d  = cnt_q - BURST_W'(1);
          end
          if (bus.end_transactionIN) state_d = S_IDLE;
        end
      end

      S_READ: begin
        if (bus.end_transactionIN) begin
          state_d = S_IDLE;  // abort: rd_vld_d stays 0
        end else begin
          xfer = rd_vld_q && !bus.busyIN;
          // Fetch the next word whenever the read register is empty or is
          // being consumed this cycle, so there is no gap after a stall.
          if (!done_q && (!rd_vld_q || !bus.busyIN)) begin
            ram_en = 1'b1;
            word_d = word_q + ADDR_WIDTH'(1);
            if (iss_q == '0) done_d = 1'b1;
            else             iss_d  = iss_q - BURST_W'(1);
          end
          rd_vld_d = ram_en || (rd_vld_q && bus.busyIN);
          if (xfer) begin
            if (cnt_q == '0) state_d = S_READ_END;
            else             cnt_d   = cnt_q - BURST_W'(1);
          end
        end
      end

      S_READ_END: state_d = S_IDLE;
      S_ERROR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      iss_q    <= '0;
      done_q   <= 1'b0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wait_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      iss_q    <= iss_d;
      done_q   <= done_d;
      rnw_q    <= rnw_d;
      be_q     <= be_d;
      wait_q   <= wait_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  sp_ram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .be    (be_q),
    .addr  (word_q),
    .wdata (bus.address_dataIN),
    .rdata (ram_rdata)
  );

  // The bus is OR-combined, so everything is forced to 0 while in reset.
  assign dv_out                 = !reset && (state_q == S_READ) && rd_vld_q;
  assign bus.data_validOUT      = dv_out;
  assign bus.address_dataOUT    = dv_out ? ram_rdata : '0;
  assign bus.end_transactionOUT = !reset && (state_q == S_READ_END);
  assign bus.busyOUT            = !reset && (state_q == S_WAIT);
  assign bus.bus_errorOUT       = !reset && (state_q == S_ERROR);

endmodule

// File: tb/tb_bus_target_ram.sv
// Scoreboard bench for bus_target_ram: stimulus pushes expected bus events,
// a negedge monitor pops and compares them. A second instance with two wait
// states covers the busyOUT path.
module tb_bus_target_ram;

  typedef enum int {K_DATA, K_END, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic [31:0] wdat [4];

  always #5 clk = ~clk;

  bus_target_ram_if b0 ();
  bus_target_ram_if b1 ();

  bus_target_ram #(.BASE_ADDRESS(32'h00F0_0000), .ADDR_WIDTH(9), .WAIT_STATES(0))
    dut (.clock(clk), .reset(reset), .bus(b0));
  bus_target_ram #(.BASE_ADDRESS(32'h00F0_0000), .ADDR_WIDTH(9), .WAIT_STATES(2))
    dut_w (.clock(clk), .reset(reset), .bus(b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] outs0();
    return b0.address_dataOUT | {28'd0, b0.end_transactionOUT, b0.data_validOUT,
                                 b0.busyOUT, b0.bus_errorOUT};
  endfunction

  task automatic exp_data(input logic [31:0] d);
    sb_q.push_back('{K_DATA, d});
  endtask
  task automatic exp_end();
    sb_q.push_back('{K_END, 32'd0});
  endtask
  task automatic exp_err();
    sb_q.push_back('{K_ERR, 32'd0});
  endtask

  task automatic observe(input kind_e kind, input logic [31:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: got kind %0d data 0x%08h, expected no event", kind, data);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_data", data, e.data);
    end
  endtask

  // Monitor: every transferred read beat, end pulse and error pulse on b0.
  always @(negedge clk) begin
    if (b0.data_validOUT && !b0.busyIN) observe(K_DATA, b0.address_dataOUT);
    if (b0.end_transactionOUT)          observe(K_END, 32'd0);
    if (b0.bus_errorOUT)                observe(K_ERR, 32'd0);
  end

  task automatic idle_b0();
    b0.address_dataIN = '0; b0.byte_enableIN = '0; b0.burst_sizeIN = '0;
    b0.read_n_writeIN = 1'b0; b0.begin_transactionIN = 1'b0;
    b0.end_transactionIN = 1'b0; b0.data_validIN = 1'b0; b0.busyIN = 1'b0;
  endtask

  task automatic idle_b1();
    b1.address_dataIN = '0; b1.byte_enableIN = '0; b1.burst_sizeIN = '0;
    b1.read_n_writeIN = 1'b0; b1.begin_transactionIN = 1'b0;
    b1.end_transactionIN = 1'b0; b1.data_validIN = 1'b0; b1.busyIN = 1'b0;
  endtask

  // n_beats beats from wdat[]; end either on its own cycle or with the last beat.
  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] be,
                          input logic [7:0] burst, input int n_beats, input bit sep_end);
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b1; b0.address_dataIN = addr;
    b0.byte_enableIN = be; b0.burst_sizeIN = burst; b0.read_n_writeIN = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      @(posedge clk) #1;
      b0.begin_transactionIN = 1'b0;
      b0.address_dataIN = wdat[i];
      b0.data_validIN = 1'b1;
      b0.end_transactionIN = !sep_end && (i == n_beats - 1);
    end
    @(posedge clk) #1;
    b0.data_validIN = 1'b0; b0.address_dataIN = '0;
    b0.end_transactionIN = sep_end;
    @(posedge clk) #1;
    idle_b0();
  endtask

  // Cycle c=0 is the cycle after the begin cycle; busy_mask[c] drives busyIN.
  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] burst,
                          input logic [15:0] busy_mask, input logic [31:0] hold_val,
                          input int exp_end_cycle);
    int  c;
    int  end_c;
    bit  seen;
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b1; b0.address_dataIN = addr;
    b0.burst_sizeIN = burst; b0.read_n_writeIN = 1'b1; b0.byte_enableIN = 4'hF;
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b0; b0.address_dataIN = '0; b0.read_n_writeIN = 1'b0;
    b0.busyIN = busy_mask[0];
    @(negedge clk);
    check("rd_no_valid_first_cycle", 32'(b0.data_validOUT), 32'd0);
    c = 1; seen = 1'b0; end_c = -1;
    while (!seen && c < 40) begin
      @(posedge clk) #1;
      b0.busyIN = (c < 16) ? busy_mask[c[3:0]] : 1'b0;
      @(negedge clk);
      if (c == 1) check("rd_first_valid", 32'(b0.data_validOUT), 32'd1);
      if (c < 16 && busy_mask[c[3:0]]) begin
        check("rd_hold_valid", 32'(b0.data_validOUT), 32'd1);
        check("rd_hold_data", b0.address_dataOUT, hold_val);
      end
      if (b0.end_transactionOUT) begin
        seen = 1'b1;
        end_c = c;
      end
      c++;
    end
    b0.busyIN = 1'b0;
    check("rd_end_cycle", 32'(end_c), 32'(exp_end_cycle));
    @(posedge clk) #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    logic [31:0] d;
    logic [31:0] acc;

    idle_b0();
    idle_b1();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero", outs0(), 32'd0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs_zero", outs0(), 32'd0);

    // Write burst of four words at word 4.
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    wr_burst(32'h00F0_0010, 4'hF, 8'd3, 4, 1'b1);

    // Read back, no stall: beats at c=1..4, end at c=5.
    exp_data(32'h11); exp_data(32'h22); exp_data(32'h33); exp_data(32'h44); exp_end();
    rd_burst(32'h00F0_0010, 8'd3, 16'h0000, 32'd0, 5);

    // Read with beat 2 (0x22) stalled for three cycles.
    exp_data(32'h11); exp_data(32'h22); exp_data(32'h33); exp_data(32'h44); exp_end();
    rd_burst(32'h00F0_0010, 8'd3, 16'h001C, 32'h22, 8);

    // Reset mid-read: 0x11 transfers, then reset clears everything.
    exp_data(32'h11);
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b1; b0.address_dataIN = 32'h00F0_0010;
    b0.burst_sizeIN = 8'd3; b0.read_n_writeIN = 1'b1;
    @(posedge clk) #1;
    idle_b0();
    @(posedge clk) #1;
    @(posedge clk) #1 reset = 1'b1;
    @(negedge clk);
    check("reset_mid_read_during", outs0(), 32'd0);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_read_after", outs0(), 32'd0);
    @(negedge clk);
    check("reset_mid_read_idle", outs0(), 32'd0);

    // Byte enables: 0x11223344 then 0xAABBCCDD on lanes 0 and 2.
    wdat[0] = 32'h1122_3344;
    wr_burst(32'h00F0_0020, 4'hF, 8'd0, 1, 1'b1);
    wdat[0] = 32'hAABB_CCDD;
    wr_burst(32'h00F0_0020, 4'b0101, 8'd0, 1, 1'b0);
    exp_data(32'h11BB_33DD); exp_end();
    rd_burst(32'h00F0_0020, 8'd0, 16'h0000, 32'd0, 2);

    // Surplus write beat: single-beat burst given two beats.
    wdat[0] = 32'h5A5A_0001; wdat[1] = 32'h5A5A_0002;
    exp_err();
    wr_burst(32'h00F0_0030, 4'hF, 8'd0, 2, 1'b1);
    exp_data(32'h5A5A_0001); exp_end();
    rd_burst(32'h00F0_0030, 8'd0, 16'h0000, 32'd0, 2);

    // Last two words of the window fit exactly; then an over-range burst.
    wdat[0] = 32'hCAFE_0001; wdat[1] = 32'hCAFE_0002;
    wr_burst(32'h00F0_07F8, 4'hF, 8'd1, 2, 1'b1);
    exp_err();
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b1; b0.address_dataIN = 32'h00F0_07F8;
    b0.burst_sizeIN = 8'd3; b0.byte_enableIN = 4'hF; b0.read_n_writeIN = 1'b0;
    @(posedge clk) #1;
    idle_b0();
    @(negedge clk);
    check("range_err_pulse", 32'(b0.bus_errorOUT), 32'd1);
    @(negedge clk);
    check("range_err_one_cycle", 32'(b0.bus_errorOUT), 32'd0);
    exp_data(32'hCAFE_0001); exp_data(32'hCAFE_0002); exp_end();
    rd_burst(32'h00F0_07F8, 8'd1, 16'h0000, 32'd0, 3);

    // Out-of-window begin: no response at all.
    @(posedge clk) #1;
    b0.begin_transactionIN = 1'b1; b0.address_dataIN = 32'h00E0_0000;
    b0.burst_sizeIN = 8'd0; b0.read_n_writeIN = 1'b1;
    @(posedge clk) #1;
    idle_b0();
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc |= outs0();
    end
    check("out_of_window_silent", acc, 32'd0);

    // Two wait states: beats offered during busyOUT must be ignored.
    @(posedge clk) #1;
    b1.begin_transactionIN = 1'b1; b1.address_dataIN = 32'h00F0_0040;
    b1.byte_enableIN = 4'hF; b1.burst_sizeIN = 8'd0; b1.read_n_writeIN = 1'b0;
    @(posedge clk) #1;
    b1.begin_transactionIN = 1'b0;
    b1.address_dataIN = 32'hDEAD_0000; b1.data_validIN = 1'b1;
    @(negedge clk);
    check("ws_busy_cycle0", 32'(b1.busyOUT), 32'd1);
    @(negedge clk);
    check("ws_busy_cycle1", 32'(b1.busyOUT), 32'd1);
    @(posedge clk) #1;
    b1.address_dataIN = 32'h0000_BEEF; b1.end_transactionIN = 1'b1;
    @(negedge clk);
    check("ws_busy_released", 32'(b1.busyOUT), 32'd0);
    @(posedge clk) #1;
    idle_b1();
    @(negedge clk);
    check("ws_no_error", 32'(b1.bus_errorOUT), 32'd0);
    @(posedge clk) #1;
    b1.begin_transactionIN = 1'b1; b1.address_dataIN = 32'h00F0_0040;
    b1.burst_sizeIN = 8'd0; b1.read_n_writeIN = 1'b1;
    @(posedge clk) #1;
    idle_b1();
    first = -1; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b1.data_validOUT && first < 0) begin
        first = c;
        d = b1.address_dataOUT;
      end
    end
    check("ws_read_latency", 32'(first), 32'd3);
    check("ws_read_data", d, 32'h0000_BEEF);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
